// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// Sequences PC / IF/ID / ID/EX / EX/MEM holds and flushes for load-use
// stalls, taken-branch flushes and data-memory freezes, and keeps
// saturating stall and flush event counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int LU_CYCLES   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [4:0]       idex_rt,
    input  logic             idex_memtoreg,
    input  logic             idex_regwr,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        LU_STALL = 2'd2
    } state_t;

    // Down-counter is wide enough for the longer of the two sequences.
    localparam int MAXC = (FLUSH_DEPTH > LU_CYCLES) ? FLUSH_DEPTH : LU_CYCLES;
    localparam int DW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
    localparam logic [DW-1:0] FD_LOAD = DW'(FLUSH_DEPTH - 1);
    localparam logic [DW-1:0] LU_LOAD = DW'(LU_CYCLES - 1);

    state_t        state;
    state_t        nxt_state;
    logic [DW-1:0] cnt;
    logic [DW-1:0] nxt_cnt;
    logic          load_use;
    logic          accept_br;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Load in ID/EX whose destination is read by the instruction in IF/ID.
    always_comb begin
        load_use = idex_memtoreg & idex_regwr & (idex_rt != 5'd0) &
                   ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
    end

    // Output decode and next-state: freeze beats branch beats load-use.
    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        accept_br  = 1'b0;
        nxt_state  = state;
        nxt_cnt    = cnt;
        if (rst) begin
            if (mem_busy) begin
                // ID/EX is frozen by the external freeze wiring, so no bubble here.
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                exmem_hold = 1'b1;
            end else begin
                unique case (state)
                    BR_FLUSH: begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        if (cnt <= DW'(1)) begin
                            nxt_state = RUN;
                            nxt_cnt   = '0;
                        end else begin
                            nxt_cnt = cnt - 1'b1;
                        end
                    end
                    LU_STALL: begin
                        if (branch_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                            accept_br  = 1'b1;
                            nxt_state  = (FLUSH_DEPTH > 1) ? BR_FLUSH : RUN;
                            nxt_cnt    = (FLUSH_DEPTH > 1) ? FD_LOAD : '0;
                        end else begin
                            pc_hold    = 1'b1;
                            ifid_hold  = 1'b1;
                            idex_flush = 1'b1;
                            if (cnt <= DW'(1)) begin
                                nxt_state = RUN;
                                nxt_cnt   = '0;
                            end else begin
                                nxt_cnt = cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (branch_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                            accept_br  = 1'b1;
                            nxt_state  = (FLUSH_DEPTH > 1) ? BR_FLUSH : RUN;
                            nxt_cnt    = (FLUSH_DEPTH > 1) ? FD_LOAD : '0;
                        end else if (load_use) begin
                            pc_hold    = 1'b1;
                            ifid_hold  = 1'b1;
                            idex_flush = 1'b1;
                            nxt_state  = (LU_CYCLES > 1) ? LU_STALL : RUN;
                            nxt_cnt    = (LU_CYCLES > 1) ? LU_LOAD : '0;
                        end
                    end
                endcase
            end
        end
    end

    // Sequencer state; reset aborts any stall or flush in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold)   stall_cnt <= sat_inc(stall_cnt);
            if (accept_br) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance a uses default parameters,
// instance b uses FLUSH_DEPTH=2, LU_CYCLES=3, CNT_W=4; both share inputs.
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] NONE   = 5'b00000;
    localparam logic [4:0] STALL  = 5'b11010; // pc_hold,ifid_hold,idex_flush
    localparam logic [4:0] FLUSH  = 5'b00110; // ifid_flush,idex_flush
    localparam logic [4:0] FREEZE = 5'b11001; // pc_hold,ifid_hold,exmem_hold

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_memtoreg, idex_regwr;
    logic       branch_taken, mem_busy, cnt_clr;

    logic        pc_hold_a, ifid_hold_a, ifid_flush_a, idex_flush_a, exmem_hold_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic        pc_hold_b, ifid_hold_b, ifid_flush_b, idex_flush_b, exmem_hold_b;
    logic [3:0]  stall_cnt_b, flush_cnt_b;
    logic [4:0]  a_out, b_out;

    int vecs = 0;
    int errs = 0;

    assign a_out = {pc_hold_a, ifid_hold_a, ifid_flush_a, idex_flush_a, exmem_hold_a};
    assign b_out = {pc_hold_b, ifid_hold_b, ifid_flush_b, idex_flush_b, exmem_hold_b};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_a (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_memtoreg(idex_memtoreg),
        .idex_regwr(idex_regwr), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .pc_hold(pc_hold_a), .ifid_hold(ifid_hold_a),
        .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .exmem_hold(exmem_hold_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipe_hazard_ctrl #(.FLUSH_DEPTH(2), .LU_CYCLES(3), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_rt(idex_rt), .idex_memtoreg(idex_memtoreg),
        .idex_regwr(idex_regwr), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .pc_hold(pc_hold_b), .ifid_hold(ifid_hold_b),
        .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .exmem_hold(exmem_hold_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0; ifid_uses_rt = 0;
        idex_memtoreg = 0; idex_regwr = 0; branch_taken = 0;
        mem_busy = 0; cnt_clr = 0;
    endtask

    task automatic set_lw_r5();
        idex_memtoreg = 1; idex_regwr = 1; idex_rt = 5; ifid_rs = 5;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        branch_taken = 1; mem_busy = 1; set_lw_r5();
        tick();
        tick();
        @(negedge clk);
        vecs++; if (a_out !== NONE) begin errs++; $display("FAIL reset_out_a got %b want %b", a_out, NONE); end
        vecs++; if (b_out !== NONE) begin errs++; $display("FAIL reset_out_b got %b want %b", b_out, NONE); end
        vecs++; if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0) begin errs++;
            $display("FAIL reset_cnt_a got %0d/%0d want 0/0", stall_cnt_a, flush_cnt_a); end
        vecs++; if (stall_cnt_b !== 4'd0 || flush_cnt_b !== 4'd0) begin errs++;
            $display("FAIL reset_cnt_b got %0d/%0d want 0/0", stall_cnt_b, flush_cnt_b); end
        clear_inputs();
        tick();
        rst = 1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw_r5();
        @(negedge clk);
        vecs++; if (a_out !== STALL) begin errs++; $display("FAIL lu_stall got %b want %b", a_out, STALL); end
        tick();
        clear_inputs();
        @(negedge clk);
        vecs++; if (a_out !== NONE) begin errs++; $display("FAIL lu_after got %b want %b", a_out, NONE); end
        vecs++; if (stall_cnt_a !== 16'd1) begin errs++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt_a); end
        tick();
    endtask

    task automatic test_no_stall();
        do_reset();
        idex_memtoreg = 1; idex_regwr = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 1;
        @(negedge clk);
        vecs++; if (a_out !== NONE) begin errs++; $display("FAIL ns_rt0 got %b want %b", a_out, NONE); end
        tick();
        idex_rt = 5; ifid_rs = 3; ifid_rt = 5; ifid_uses_rt = 0;
        @(negedge clk);
        vecs++; if (a_out !== NONE) begin errs++; $display("FAIL ns_nouse got %b want %b", a_out, NONE); end
        tick();
        idex_regwr = 0; ifid_uses_rt = 1;
        @(negedge clk);
        vecs++; if (a_out !== NONE) begin errs++; $display("FAIL ns_noregwr got %b want %b", a_out, NONE); end
        tick();
        idex_regwr = 1;
        @(negedge clk);
        vecs++; if (a_out !== STALL) begin errs++; $display("FAIL ns_rt_match got %b want %b", a_out, STALL); end
        tick();
        clear_inputs();
        @(negedge clk);
        vecs++; if (stall_cnt_a !== 16'd1) begin errs++; $display("FAIL ns_stall_cnt got %0d want 1", stall_cnt_a); end
        tick();
    endtask

    task automatic test_branch_flush();
        do_reset();
        branch_taken = 1;
        @(negedge clk);
        vecs++; if (b_out !== FLUSH) begin errs++; $display("FAIL br_c1_b got %b want %b", b_out, FLUSH); end
        vecs++; if (a_out !== FLUSH) begin errs++; $display("FAIL br_c1_a got %b want %b", a_out, FLUSH); end
        tick();
        @(negedge clk);
        vecs++; if (b_out !== FLUSH) begin errs++; $display("FAIL br_c2_b got %b want %b", b_out, FLUSH); end
        tick();
        branch_taken = 0;
        @(negedge clk);
        vecs++; if (b_out !== NONE) begin errs++; $display("FAIL br_c3_b got %b want %b", b_out, NONE); end
        vecs++; if (flush_cnt_b !== 4'd1) begin errs++; $display("FAIL br_flush_cnt_b got %0d want 1", flush_cnt_b); end
        vecs++; if (flush_cnt_a !== 16'd2) begin errs++; $display("FAIL br_flush_cnt_a got %0d want 2", flush_cnt_a); end
        tick();
    endtask

    task automatic test_branch_vs_lu();
        do_reset();
        branch_taken = 1; set_lw_r5();
        @(negedge clk);
        vecs++; if (a_out !== FLUSH) begin errs++; $display("FAIL bvl_flush got %b want %b", a_out, FLUSH); end
        tick();
        clear_inputs();
        @(negedge clk);
        vecs++; if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd0) begin errs++;
            $display("FAIL bvl_cnts got %0d/%0d want 1/0", flush_cnt_a, stall_cnt_a); end
        tick();
        branch_taken = 1; set_lw_r5(); mem_busy = 1;
        @(negedge clk);
        vecs++; if (a_out !== FREEZE) begin errs++; $display("FAIL bvl_freeze_a got %b want %b", a_out, FREEZE); end
        vecs++; if (b_out !== FREEZE) begin errs++; $display("FAIL bvl_freeze_b got %b want %b", b_out, FREEZE); end
        tick();
        mem_busy = 0;
        @(negedge clk);
        vecs++; if (a_out !== FLUSH) begin errs++; $display("FAIL bvl_after_freeze got %b want %b", a_out, FLUSH); end
        vecs++; if (stall_cnt_a !== 16'd1) begin errs++; $display("FAIL bvl_freeze_stall got %0d want 1", stall_cnt_a); end
        tick();
        clear_inputs();
        @(negedge clk);
        vecs++; if (flush_cnt_a !== 16'd2) begin errs++; $display("FAIL bvl_flush_cnt2 got %0d want 2", flush_cnt_a); end
        tick();
    endtask

    task automatic test_lu_freeze();
        do_reset();
        set_lw_r5();
        @(negedge clk);
        vecs++; if (b_out !== STALL) begin errs++; $display("FAIL luf_c1 got %b want %b", b_out, STALL); end
        tick();
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++; if (b_out !== FREEZE) begin errs++; $display("FAIL luf_freeze%0d got %b want %b", i, b_out, FREEZE); end
            tick();
        end
        mem_busy = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vecs++; if (b_out !== STALL) begin errs++; $display("FAIL luf_resume%0d got %b want %b", i, b_out, STALL); end
            tick();
        end
        @(negedge clk);
        vecs++; if (b_out !== NONE) begin errs++; $display("FAIL luf_done got %b want %b", b_out, NONE); end
        vecs++; if (stall_cnt_b !== 4'd7) begin errs++; $display("FAIL luf_stall_cnt got %0d want 7", stall_cnt_b); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        vecs++; if (stall_cnt_b !== 4'd15) begin errs++; $display("FAIL sat_b got %0d want 15", stall_cnt_b); end
        vecs++; if (stall_cnt_a !== 16'd20) begin errs++; $display("FAIL sat_a got %0d want 20", stall_cnt_a); end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        @(negedge clk);
        vecs++; if (stall_cnt_b !== 4'd0 || stall_cnt_a !== 16'd0) begin errs++;
            $display("FAIL sat_clr got %0d/%0d want 0/0", stall_cnt_a, stall_cnt_b); end
        mem_busy = 0;
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        branch_taken = 1;
        tick();
        branch_taken = 0;
        @(negedge clk);
        vecs++; if (b_out !== FLUSH) begin errs++; $display("FAIL rmf_pre got %b want %b", b_out, FLUSH); end
        #1 rst = 0;
        #1;
        vecs++; if (b_out !== NONE) begin errs++; $display("FAIL rmf_abort got %b want %b", b_out, NONE); end
        vecs++; if (flush_cnt_b !== 4'd0) begin errs++; $display("FAIL rmf_cnt got %0d want 0", flush_cnt_b); end
        tick();
        rst = 1;
        @(negedge clk);
        vecs++; if (b_out !== NONE) begin errs++; $display("FAIL rmf_run got %b want %b", b_out, NONE); end
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        #1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_flush();
        test_branch_vs_lu();
        test_lu_freeze();
        test_saturate();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
